alu_sequencer: RTL and testbench

Command-side initiator for the 8-bit combinational ALU. It accepts register-transfer commands over a valid/ready handshake and holds a small register file. It drives operands and opcode to the external ALU, captures result and zero flag, writes the result back, and returns it on a valid/ready response channel. It sits between the CPU control path and the ALU instance.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encoding and default width for the ALU sequencer.
package alu_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NAND  = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_SHR1  = 3'b110;
    localparam logic [2:0] OP_SHL1H = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NUM_REGS x DATA_W register file, two async read ports, one sync write port.
//   clk, rst              clock, synchronous active-high reset (clears all registers)
//   we_i, waddr_i, wdata_i write port
//   raddr_a_i/rdata_a_o   read port A
//   raddr_b_i/rdata_b_o   read port B
module alu_regfile import alu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side initiator for an external combinational ALU.
//   cmd_*        command channel (valid/ready): load immediate or ALU op on registers
//   alu_operand_a/b, alu_op  registered drive to the external ALU
//   alu_result, alu_zero     combinational return from the ALU
//   rsp_*        response channel (valid/ready): value written to cmd_dst and its zero flag
//   sticky_zero  present only when ALU_ZERO_STICKY_EN is defined
module alu_sequencer import alu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_dst,
    input  logic [REG_AW-1:0] cmd_srca,
    input  logic [REG_AW-1:0] cmd_srcb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero
`ifdef ALU_ZERO_STICKY_EN
    ,
    output logic              sticky_zero
`endif
);

    state_t            state_q, state_d;
    logic [REG_AW-1:0] dst_q, dst_d, waddr;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] rd_a, rd_b, wdata;
    logic [2:0]        op_q, op_d;
    logic              rsp_zero_q, rsp_zero_d, cmd_fire, rsp_fire, issue, we;

    assign cmd_ready = state_q == ST_IDLE;
    assign rsp_valid = state_q == ST_RESP;
    assign issue     = state_q == ST_ISSUE;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign rsp_fire  = rsp_valid & rsp_ready;

    // Single write port shared by immediate loads (IDLE) and ALU write-back (ISSUE).
    assign we    = (cmd_fire & cmd_load) | issue;
    assign waddr = issue ? dst_q : cmd_dst;
    assign wdata = issue ? alu_result : cmd_imm;

    alu_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (cmd_srca),
        .rdata_a_o (rd_a),
        .raddr_b_i (cmd_srcb),
        .rdata_b_o (rd_b)
    );

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire && cmd_load) begin
                    rsp_data_d = cmd_imm;
                    rsp_zero_d = cmd_imm == '0;
                    state_d    = ST_RESP;
                end else if (cmd_fire) begin
                    dst_d   = cmd_dst;
                    opa_d   = rd_a;
                    opb_d   = rd_b;
                    op_d    = cmd_op;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rsp_data_d = alu_result;
                rsp_zero_d = alu_zero;
                state_d    = ST_RESP;
            end
            ST_RESP:  state_d = rsp_fire ? ST_IDLE : ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dst_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign alu_operand_a = opa_q;
    assign alu_operand_b = opb_q;
    assign alu_op        = op_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_zero      = rsp_zero_q;

`ifdef ALU_ZERO_STICKY_EN
    logic sticky_q, sticky_d;
    // Loading all-ones clears the flag; clear takes priority over set.
    assign sticky_d = (cmd_fire && cmd_load && cmd_imm == '1) ? 1'b0 :
                      (rsp_fire && rsp_zero_q)               ? 1'b1 : sticky_q;
    always_ff @(posedge clk) begin
        if (rst) sticky_q <= 1'b0;
        else     sticky_q <= sticky_d;
    end
    assign sticky_zero = sticky_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed checks of alu_sequencer against a register-array model.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_load;
    logic [2:0] cmd_op, alu_op;
    logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
    logic [7:0] cmd_imm, alu_operand_a, alu_operand_b, alu_result, rsp_data;
    logic       alu_zero, rsp_valid, rsp_ready, rsp_zero;
`ifdef ALU_ZERO_STICKY_EN
    logic       sticky_zero;
    bit         m_sticky;
`endif

    logic [7:0] model [4];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return 8'((int'(a) + int'(b)) % 256);
            3'd5:    return 8'((int'(a) - int'(b) + 256) % 256);
            3'd6:    return a / 2;
            default: return (a < 8) ? 8'(1 << a) : 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_operand_a, alu_operand_b, alu_op);
    assign alu_zero   = alu_result == 8'h00;

    alu_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_load      (cmd_load),
        .cmd_op        (cmd_op),
        .cmd_dst       (cmd_dst),
        .cmd_srca      (cmd_srca),
        .cmd_srcb      (cmd_srcb),
        .cmd_imm       (cmd_imm),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_zero      (rsp_zero)
`ifdef ALU_ZERO_STICKY_EN
        ,
        .sticky_zero   (sticky_zero)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full command: accept, optional ISSUE cycle, response with `stall` cycles of backpressure.
    // With hold_next, a second load (r3 <= 0x5A) is presented during the stall.
    task automatic do_cmd(input bit ld, input logic [2:0] op, input logic [1:0] d,
                          input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] imm,
                          input int stall, input bit hold_next);
        logic [7:0] exp;
        exp = ld ? imm : alu_fn(model[sa], model[sb], op);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_dst   = d;
        cmd_srca  = sa;
        cmd_srcb  = sb;
        cmd_imm   = imm;
        step();
        cmd_valid = 1'b0;
`ifdef ALU_ZERO_STICKY_EN
        if (ld && imm == 8'hFF) m_sticky = 1'b0;
`endif
        if (!ld) begin
            chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("issue_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("issue_opa", 32'(alu_operand_a), 32'(model[sa]));
            chk("issue_opb", 32'(alu_operand_b), 32'(model[sb]));
            chk("issue_op", 32'(alu_op), 32'(op));
            step();
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        chk("rsp_zero", 32'(rsp_zero), 32'(exp == 8'h00));
        for (int i = 0; i < stall; i++) begin
            if (hold_next) begin
                cmd_valid = 1'b1;
                cmd_load  = 1'b1;
                cmd_dst   = 2'd3;
                cmd_imm   = 8'h5A;
            end
            step();
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_data", 32'(rsp_data), 32'(exp));
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        model[d] = exp;
`ifdef ALU_ZERO_STICKY_EN
        if (exp == 8'h00) m_sticky = 1'b1;
        chk("sticky_zero", 32'(sticky_zero), 32'(m_sticky));
`endif
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_dst = '0;
        cmd_srca = '0; cmd_srcb = '0; cmd_imm = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
`ifdef ALU_ZERO_STICKY_EN
        m_sticky = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("reset_opa", 32'(alu_operand_a), 32'd0);
        chk("reset_op", 32'(alu_op), 32'd0);

        do_cmd(1'b1, OP_AND, 2'd0, 2'd0, 2'd0, 8'h0F, 0, 1'b0);
        do_cmd(1'b1, OP_AND, 2'd1, 2'd0, 2'd0, 8'hF0, 0, 1'b0);
        do_cmd(1'b0, OP_OR,  2'd2, 2'd0, 2'd1, 8'h00, 0, 1'b0);
        do_cmd(1'b0, OP_AND, 2'd3, 2'd0, 2'd1, 8'h00, 0, 1'b0);
        do_cmd(1'b1, OP_AND, 2'd0, 2'd0, 2'd0, 8'hFF, 0, 1'b0);
        do_cmd(1'b1, OP_AND, 2'd1, 2'd0, 2'd0, 8'h01, 0, 1'b0);
        do_cmd(1'b0, OP_ADD, 2'd0, 2'd0, 2'd1, 8'h00, 0, 1'b0);
        do_cmd(1'b0, OP_SUB, 2'd2, 2'd1, 2'd0, 8'h00, 0, 1'b0);
        chk("sub_result", 32'(model[2]), 32'h01);
        do_cmd(1'b0, OP_XOR, 2'd1, 2'd1, 2'd1, 8'h00, 0, 1'b0);

        do_cmd(1'b0, OP_NAND, 2'd2, 2'd2, 2'd3, 8'h00, 5, 1'b1);
        do_cmd(1'b1, OP_AND, 2'd3, 2'd0, 2'd0, 8'h5A, 0, 1'b0);

`ifdef ALU_ZERO_STICKY_EN
        do_cmd(1'b1, OP_AND, 2'd0, 2'd0, 2'd0, 8'h00, 0, 1'b0);
        do_cmd(1'b1, OP_AND, 2'd1, 2'd0, 2'd0, 8'h07, 0, 1'b0);
        do_cmd(1'b0, OP_ADD, 2'd2, 2'd1, 2'd1, 8'h00, 1, 1'b0);
        do_cmd(1'b1, OP_AND, 2'd2, 2'd0, 2'd0, 8'hFF, 0, 1'b0);
`endif

        for (int n = 0; n < 60; n++) begin
            do_cmd($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
                   $urandom_range(0, 3), 1'b0);
        end

        do_cmd(1'b1, OP_AND, 2'd1, 2'd0, 2'd0, 8'h33, 0, 1'b0);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD;
        cmd_dst = 2'd1; cmd_srca = 2'd1; cmd_srcb = 2'd1;
        step();
        cmd_valid = 1'b0;
        chk("abort_in_issue", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
`ifdef ALU_ZERO_STICKY_EN
        m_sticky = 1'b0;
        chk("abort_sticky", 32'(sticky_zero), 32'd0);
`endif
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_opa", 32'(alu_operand_a), 32'd0);
        chk("abort_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 4; i++)
            do_cmd(1'b0, OP_OR, 2'(i), 2'(i), 2'(i), 8'h00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
